// File: rtl/pat_det_arb.sv
// pat_det_arb: round-robin sharing of one serial pattern detector among N_CH bit streams,
// with per-frame detector clear, hit attribution to the owning channel and saturating hit counters.
module pat_det_arb #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_CH-1:0]       req_i,
    input  logic [N_CH-1:0]       d_i,
    input  logic [N_CH-1:0]       valid_i,
    input  logic [N_CH-1:0]       last_i,
    output logic [N_CH-1:0]       ready_o,
    output logic [N_CH-1:0]       gnt_o,
    output logic                  det_rst_o,
    output logic                  det_d_o,
    output logic                  det_valid_o,
    input  logic                  det_hit_i,
    output logic [N_CH-1:0]       hit_o,
    output logic [N_CH*CNT_W-1:0] hit_cnt_o,
    input  logic [N_CH-1:0]       cnt_clr_i
);
    localparam logic [1:0] IDLE = 2'd0, CLR = 2'd1, STREAM = 2'd2, DRAIN = 2'd3;
    logic [1:0]      state;
    logic [N_CH-1:0] last_gnt, hi_req, pick, hit_ev;
    logic            acc_last;
    // requests strictly above the last grant win; otherwise wrap to the lowest request
    always_comb begin
        hi_req = req_i & ~((last_gnt << 1) - N_CH'(1));
        pick   = (|hi_req) ? (hi_req & (~hi_req + N_CH'(1))) : (req_i & (~req_i + N_CH'(1)));
    end
    assign ready_o     = (state == STREAM) ? gnt_o : '0;
    assign det_valid_o = |(valid_i & ready_o);
    assign det_d_o     = |(d_i & valid_i & ready_o);
    assign acc_last    = |(last_i & valid_i & ready_o);
    assign hit_ev      = (det_hit_i && (state == STREAM || state == DRAIN)) ? gnt_o : '0;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            gnt_o     <= '0;
            last_gnt  <= {1'b1, {(N_CH-1){1'b0}}};
            det_rst_o <= 1'b0;
            hit_o     <= '0;
        end else begin
            det_rst_o <= (state == IDLE) && (|req_i);
            hit_o     <= hit_ev;
            if (state == IDLE && |req_i) begin
                gnt_o    <= pick;
                last_gnt <= pick;
                state    <= CLR;
            end else if (state == CLR) begin
                state <= STREAM;
            end else if (state == STREAM && acc_last) begin
                state <= DRAIN;
            end else if (state == DRAIN) begin
                gnt_o <= '0;
                state <= IDLE;
            end
        end
    end
    for (genvar k = 0; k < N_CH; k++) begin : g_cnt
        logic [CNT_W-1:0] cnt;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)
                cnt <= '0;
            else if (cnt_clr_i[k])
                cnt <= '0;
            else if (hit_ev[k] && !(&cnt))
                cnt <= cnt + CNT_W'(1);
        end
        assign hit_cnt_o[k*CNT_W +: CNT_W] = cnt;
    end
endmodule

// File: tb/tb_pat_det_arb.sv
// tb_pat_det_arb: directed stimulus with queued expectations checked by an independent monitor.
module tb_pat_det_arb;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  req_i, d_i, valid_i, last_i, cnt_clr_i;
    logic [3:0]  ready_o, gnt_o, hit_o;
    logic        det_rst_o, det_d_o, det_valid_o, det_hit_i;
    logic [31:0] hit_cnt_o;
    int          total = 0;
    int          bad = 0;
    logic [3:0]  q_gnt[$];
    logic [11:0] q_hit[$];
    logic [7:0]  cnt_m[4];
    logic [3:0]  own = '0;
    logic        prev_ready = 1'b0, prev_rst = 1'b0;

    pat_det_arb #(.N_CH(4), .CNT_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .d_i(d_i), .valid_i(valid_i),
        .last_i(last_i), .ready_o(ready_o), .gnt_o(gnt_o), .det_rst_o(det_rst_o),
        .det_d_o(det_d_o), .det_valid_o(det_valid_o), .det_hit_i(det_hit_i),
        .hit_o(hit_o), .hit_cnt_o(hit_cnt_o), .cnt_clr_i(cnt_clr_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_cnt();
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[k*8 +: 8] = cnt_m[k];
        return r;
    endfunction

    task automatic bump(input int ch);
        cnt_m[ch] = (cnt_m[ch] == 8'hff) ? 8'hff : cnt_m[ch] + 8'd1;
    endtask

    // monitor: checks grants, stream muxing and hit pulses against the queues
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (det_rst_o) begin
                if (q_gnt.size() == 0) begin
                    total++; bad++;
                    $display("FAIL clr_unexpected act=%0h req=none", gnt_o);
                end else begin
                    own = q_gnt.pop_front();
                    chk("gnt_order", gnt_o, own);
                    chk("clr_ready", ready_o, 4'd0);
                end
            end
            chk("clr_len", det_rst_o & prev_rst, 0);
            if (ready_o != 0 && !prev_ready) chk("clr_before_ready", prev_rst, 1);
            if (ready_o != 0) begin
                chk("ready_owner", ready_o, own);
                chk("dv_mirror", det_valid_o, |(valid_i & own));
                chk("dd_mirror", det_d_o, |(d_i & valid_i & own));
            end else begin
                chk("dv_idle", det_valid_o, 0);
                chk("dd_idle", det_d_o, 0);
            end
            chk("gnt_onehot0", $onehot0(gnt_o), 1);
            if (hit_o != 0) begin
                if (q_hit.size() == 0) begin
                    total++; bad++;
                    $display("FAIL hit_unexpected act=%0h req=none", hit_o);
                end else begin
                    logic [11:0] e;
                    int ch;
                    e = q_hit.pop_front();
                    ch = 0;
                    for (int k = 0; k < 4; k++) if (e[8+k]) ch = k;
                    chk("hit_ch", hit_o, e[11:8]);
                    chk("hit_cnt", hit_cnt_o[ch*8 +: 8], e[7:0]);
                end
            end
            prev_ready = ready_o != 0;
            prev_rst = det_rst_o;
        end
    end

    task automatic wait_ready(output int ch, output bit ok);
        ok = 0;
        ch = 0;
        for (int w = 0; w < 20 && !ok; w++) begin
            if (ready_o != 0) ok = 1;
            else begin @(posedge clk_i); #1; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL ready_timeout act=%0h req=nonzero", ready_o);
        end
        for (int k = 0; k < 4; k++) if (ready_o[k]) ch = k;
    endtask

    task automatic run_frame(input int n, input logic [15:0] bits, input logic [15:0] gaps,
                             input bit hit, input bit drop, input bit noise);
        int ch;
        bit ok;
        logic [3:0] oh;
        wait_ready(ch, ok);
        if (!ok) return;
        oh = 4'(1 << ch);
        if (drop) req_i = '0;
        for (int i = 0; i < n; i++) begin
            if (gaps[i]) begin
                valid_i = noise ? ~oh : '0;
                last_i = noise ? ~oh : '0;
                d_i = noise ? ~oh : '0;
                @(posedge clk_i); #1;
                chk("gap_hold", ready_o, oh);
            end
            valid_i = noise ? ((4'($urandom) & ~oh) | oh) : oh;
            last_i = noise ? (4'($urandom) & ~oh) : '0;
            last_i[ch] = (i == n - 1);
            d_i = noise ? (4'($urandom) & ~oh) : '0;
            d_i[ch] = bits[i];
            @(posedge clk_i); #1;
            if (i < n - 1) chk("stream_hold", ready_o, oh);
        end
        valid_i = '0; last_i = '0; d_i = '0;
        chk("drain_ready", ready_o, 0);
        if (hit) begin
            det_hit_i = 1;
            bump(ch);
            q_hit.push_back({oh, cnt_m[ch]});
        end
        @(posedge clk_i); #1;
        det_hit_i = 0;
        chk("gnt_clear", gnt_o, 0);
    endtask

    initial begin
        int ch;
        bit ok;
        rst_i = 1; req_i = '0; d_i = '0; valid_i = '0; last_i = '0; cnt_clr_i = '0; det_hit_i = 0;
        for (int k = 0; k < 4; k++) cnt_m[k] = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_gnt", gnt_o, 0);
        chk("rst_ready", ready_o, 0);
        chk("rst_det_rst", det_rst_o, 0);
        chk("rst_hit", hit_o, 0);
        chk("rst_cnt", hit_cnt_o, 0);
        rst_i = 0;

        // all channels requesting: rotation 0,1,2,3,0
        q_gnt.push_back(4'b0001); q_gnt.push_back(4'b0010); q_gnt.push_back(4'b0100);
        q_gnt.push_back(4'b1000); q_gnt.push_back(4'b0001);
        req_i = 4'b1111;
        for (int f = 0; f < 5; f++) run_frame(3, 16'b101, 16'd0, 0, f == 4, 0);

        // ch1 streams 1,1,0,1,1 with a hit during drain
        q_gnt.push_back(4'b0010);
        req_i = 4'b0010;
        run_frame(5, 16'b11011, 16'd0, 1, 1, 0);
        chk("t1_counts", hit_cnt_o, 32'h0000_0100);

        // ch3 with valid gaps and noisy non-owners
        q_gnt.push_back(4'b1000);
        req_i = 4'b1000;
        run_frame(4, 16'b1101, 16'b0110, 1, 1, 1);
        chk("t3_counts", hit_cnt_o, model_cnt());

        // ch0 saturation, then clear colliding with a hit
        q_gnt.push_back(4'b0001);
        req_i = 4'b0001;
        wait_ready(ch, ok);
        req_i = '0;
        for (int i = 0; i < 257; i++) begin
            det_hit_i = 1;
            bump(0);
            q_hit.push_back({4'b0001, cnt_m[0]});
            @(posedge clk_i); #1;
        end
        chk("sat_value", hit_cnt_o[7:0], 8'hff);
        cnt_clr_i = 4'b0001;
        cnt_m[0] = '0;
        q_hit.push_back({4'b0001, 8'd0});
        @(posedge clk_i); #1;
        det_hit_i = 0; cnt_clr_i = '0;
        chk("clr_wins", hit_cnt_o[7:0], 8'd0);
        valid_i = 4'b0001; last_i = 4'b0001;
        @(posedge clk_i); #1;
        valid_i = '0; last_i = '0;
        @(posedge clk_i); #1;
        chk("sat_counts", hit_cnt_o, model_cnt());

        // hits during IDLE and CLR are ignored
        det_hit_i = 1;
        repeat (3) @(posedge clk_i);
        #1;
        det_hit_i = 0;
        chk("idle_hit_cnt", hit_cnt_o, model_cnt());
        q_gnt.push_back(4'b0100);
        req_i = 4'b0100;
        ok = 0;
        for (int w = 0; w < 10 && !ok; w++) begin
            @(posedge clk_i); #1;
            ok = det_rst_o;
        end
        chk("clr_seen", ok, 1);
        det_hit_i = 1;
        @(posedge clk_i); #1;
        det_hit_i = 0;
        run_frame(2, 16'b01, 16'd0, 0, 1, 0);
        chk("clr_hit_cnt", hit_cnt_o, model_cnt());

        // async reset in the middle of a ch2 frame
        q_gnt.push_back(4'b0100);
        req_i = 4'b0100;
        wait_ready(ch, ok);
        req_i = '0;
        d_i = 4'b0100; valid_i = 4'b0100;
        @(posedge clk_i); #1;
        det_hit_i = 1;
        @(posedge clk_i); #1;
        det_hit_i = 0;
        chk("pre_rst_hit", hit_o, 4'b0100);
        #2 rst_i = 1;
        #1;
        chk("arst_gnt", gnt_o, 0);
        chk("arst_ready", ready_o, 0);
        chk("arst_dv", det_valid_o, 0);
        chk("arst_hit", hit_o, 0);
        chk("arst_cnt", hit_cnt_o, 0);
        for (int k = 0; k < 4; k++) cnt_m[k] = '0;
        d_i = '0; valid_i = '0;
        @(posedge clk_i); #1;
        rst_i = 0;
        q_gnt.push_back(4'b0001); q_gnt.push_back(4'b0100);
        req_i = 4'b0101;
        run_frame(2, 16'b11, 16'd0, 1, 0, 0);
        run_frame(2, 16'b10, 16'd0, 0, 1, 0);
        chk("post_rst_counts", hit_cnt_o, model_cnt());

        repeat (3) @(posedge clk_i);
        #1;
        chk("gnt_queue_empty", q_gnt.size(), 0);
        chk("hit_queue_empty", q_hit.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
